ps2_kbd_mmio_fifo: RTL and testbench



---
 rtl/ps2_kbd_pkg.sv | 87 ++++++++
 rtl/ps2_evt_fifo.sv | 55 +++++
 rtl/ps2_kbd_mmio_fifo.sv | 197 +++++++++++++++++++
 tb/tb_ps2_kbd_mmio_fifo.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared types, register offsets, scan-code constants and ASCII helpers for the PS/2 keyboard block.
package ps2_kbd_pkg;

  // Prefix decoder states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } dec_state_t;

  // Register offsets from the window base
  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_DATA   = 32'h04;
  localparam logic [31:0] OFF_HIST   = 32'h08;
  localparam logic [31:0] OFF_KEYMAP = 32'h28;

  // Scan codes with special meaning
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;

  // Bytes still to swallow after the E1 that opens the Pause sequence
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  // One queued key press; packs to 19 bits and sits in DATA[18:0]
  typedef struct packed {
    logic       caps;
    logic       shift;
    logic       ext;
    logic [7:0] scan;
    logic [7:0] ascii;
  } kbd_entry_t;

  // Set-2 scan code to ASCII; unknown codes map to 0
  function automatic logic [7:0] scan2ascii(input logic [7:0] scan, input logic shift);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = 8'h00;
    hi = 8'h00;
    case (scan)
      8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
      8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
      8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
      8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
      8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
      8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
      8'h35: lo = "y";  8'h1A: lo = "z";
      8'h45: begin lo = "0"; hi = ")"; end
      8'h16: begin lo = "1"; hi = "!"; end
      8'h1E: begin lo = "2"; hi = "@"; end
      8'h26: begin lo = "3"; hi = "#"; end
      8'h25: begin lo = "4"; hi = "$"; end
      8'h2E: begin lo = "5"; hi = "%"; end
      8'h36: begin lo = "6"; hi = "^"; end
      8'h3D: begin lo = "7"; hi = "&"; end
      8'h3E: begin lo = "8"; hi = "*"; end
      8'h46: begin lo = "9"; hi = "("; end
      8'h29: lo = 8'h20;  8'h5A: lo = 8'h0D;  8'h66: lo = 8'h08;
      8'h0D: lo = 8'h09;  8'h76: lo = 8'h1B;
      default: lo = 8'h00;
    endcase
    // Letters shift to upper case; other keys without a shifted glyph keep theirs
    if (hi == 8'h00) hi = (lo >= "a" && lo <= "z") ? lo - 8'd32 : lo;
    return shift ? hi : lo;
  endfunction

  // Caps lock swaps letter case only
  function automatic logic [7:0] caps_adjust(input logic [7:0] c, input logic caps);
    logic is_letter;
    is_letter = (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
    return (caps && is_letter) ? (c ^ 8'h20) : c;
  endfunction

  // Modifier makes update state but never reach the queue
  function automatic logic is_modifier(input logic [7:0] c);
    return (c == SC_LSHIFT) || (c == SC_RSHIFT) || (c == SC_CAPS) ||
           (c == SC_CTRL) || (c == SC_ALT);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous key-event FIFO with combinational head, flush and occupancy count.
module ps2_evt_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 19,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_pop;
  logic             do_push;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

  // A pop on an empty queue is ignored; a push into a full queue only lands if a pop frees a slot
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers and occupancy; flush discards everything including a same-cycle push
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/ps2_kbd_mmio_fifo.sv
// PS/2 keyboard front end: prefix decoder, modifiers, key map, byte history and an MMIO-read event FIFO.
module ps2_kbd_mmio_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter int          HIST_WORDS = 2,
  parameter logic [31:0] BASE_ADDR  = 32'hFF200100
) (
  input  logic        iCLK,
  input  logic        Reset,
  input  logic        iScanValid,
  input  logic [7:0]  iScanCode,
  input  logic        wReadEnable,
  input  logic        wWriteEnable,
  input  logic [3:0]  wByteEnable,
  input  logic [31:0] wAddress,
  input  logic [31:0] wWriteData,
  output logic [31:0] wReadData,
  output logic        oInterrupt,
  output logic        oOverflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HB = 4 * HIST_WORDS;
  localparam int EW = $bits(kbd_entry_t);

  dec_state_t     state_reg, state_next;
  logic [2:0]     cnt_reg, cnt_next;
  logic           is_make, is_break, ev_ext;
  logic [127:0]   keymap_reg;
  logic           lshift_reg, rshift_reg, caps_reg;
  logic           irq_en_reg, overflow_reg, data_rd_prev_reg;
  logic [7:0]     hist_reg [HB];
  logic [31:0]    hist_word [HIST_WORDS];
  logic [31:0]    offset, count_wide;
  logic           data_rd, pop, ctrl_wr, flush, push, overflow_set;
  kbd_entry_t     new_entry;
  logic [EW-1:0]  fifo_head;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           unused_bits;

  assign offset       = wAddress - BASE_ADDR;
  assign data_rd      = wReadEnable & (offset == OFF_DATA);
  assign pop          = data_rd & ~data_rd_prev_reg;
  assign ctrl_wr      = wWriteEnable & (offset == OFF_CTRL);
  assign flush        = ctrl_wr & wWriteData[3];
  assign push         = is_make & ~is_modifier(iScanCode);
  assign overflow_set = push & fifo_full & ~pop & ~flush;
  assign count_wide   = 32'(fifo_count);
  assign oInterrupt   = irq_en_reg & ~fifo_empty;
  assign oOverflow    = overflow_reg;
  assign unused_bits  = ^{wByteEnable, count_wide[31:8]};

  // Decoder state register
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Prefix decoding: classify each byte as prefix, make, break or swallowed Pause byte
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    is_make    = 1'b0;
    is_break   = 1'b0;
    ev_ext     = 1'b0;
    if (iScanValid) begin
      case (state_reg)
        ST_IDLE: begin
          if (iScanCode == SC_EXT) state_next = ST_EXT;
          else if (iScanCode == SC_BRK) state_next = ST_BRK;
          else if (iScanCode == SC_PAUSE) begin
            state_next = ST_SKIP;
            cnt_next   = PAUSE_TAIL;
          end else is_make = 1'b1;
        end
        ST_EXT: begin
          if (iScanCode == SC_BRK) state_next = ST_EXT_BRK;
          else begin
            is_make    = 1'b1;
            ev_ext     = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          is_break   = 1'b1;
          state_next = ST_IDLE;
        end
        ST_EXT_BRK: begin
          is_break   = 1'b1;
          ev_ext     = 1'b1;
          state_next = ST_IDLE;
        end
        ST_SKIP: begin
          cnt_next = cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Entry built from the current modifier state; extended keys carry no ASCII
  always_comb begin
    new_entry.caps  = caps_reg;
    new_entry.shift = lshift_reg | rshift_reg;
    new_entry.ext   = ev_ext;
    new_entry.scan  = iScanCode;
    new_entry.ascii = ev_ext ? 8'h00
                    : caps_adjust(scan2ascii(iScanCode, lshift_reg | rshift_reg), caps_reg);
  end

  // Key map and modifier tracking
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      keymap_reg <= '0;
      lshift_reg <= 1'b0;
      rshift_reg <= 1'b0;
      caps_reg   <= 1'b0;
    end else if (is_make) begin
      if (!ev_ext && !iScanCode[7]) keymap_reg[iScanCode[6:0]] <= 1'b1;
      if (iScanCode == SC_LSHIFT) lshift_reg <= 1'b1;
      if (iScanCode == SC_RSHIFT) rshift_reg <= 1'b1;
      if (iScanCode == SC_CAPS)   caps_reg   <= ~caps_reg;
    end else if (is_break) begin
      if (!ev_ext && !iScanCode[7]) keymap_reg[iScanCode[6:0]] <= 1'b0;
      if (iScanCode == SC_LSHIFT) lshift_reg <= 1'b0;
      if (iScanCode == SC_RSHIFT) rshift_reg <= 1'b0;
    end
  end

  // Raw byte history, newest byte in slot 0; every received byte shifts in
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      for (int i = 0; i < HB; i++) hist_reg[i] <= '0;
    end else if (iScanValid) begin
      hist_reg[0] <= iScanCode;
      for (int i = 1; i < HB; i++) hist_reg[i] <= hist_reg[i-1];
    end
  end

  for (genvar gi = 0; gi < HIST_WORDS; gi++) begin : g_hist_word
    assign hist_word[gi] = {hist_reg[4*gi+3], hist_reg[4*gi+2], hist_reg[4*gi+1], hist_reg[4*gi]};
  end

  // Control flags and the previous-cycle DATA read used to make pops one per access
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      irq_en_reg       <= 1'b0;
      overflow_reg     <= 1'b0;
      data_rd_prev_reg <= 1'b0;
    end else begin
      data_rd_prev_reg <= data_rd;
      if (ctrl_wr) irq_en_reg <= wWriteData[2];
      if (overflow_set) overflow_reg <= 1'b1;
      else if (ctrl_wr && wWriteData[1]) overflow_reg <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (iCLK),
    .srst      (Reset),
    .push      (push),
    .push_data (new_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Register read mux; anything unselected reads as zero
  always_comb begin
    wReadData = '0;
    if (wReadEnable) begin
      if (offset == OFF_CTRL)
        wReadData = {16'b0, count_wide[7:0], 5'b0, irq_en_reg, overflow_reg, ~fifo_empty};
      else if (offset == OFF_DATA)
        wReadData = fifo_empty ? 32'h0 : {1'b1, 12'b0, fifo_head};
      for (int k = 0; k < HIST_WORDS; k++)
        if (offset == OFF_HIST + 32'(4 * k)) wReadData = hist_word[k];
      for (int j = 0; j < 4; j++)
        if (offset == OFF_KEYMAP + 32'(4 * j)) wReadData = keymap_reg[32*j +: 32];
    end
  end

endmodule

// File: tb/tb_ps2_kbd_mmio_fifo.sv
// Randomised and directed bench for ps2_kbd_mmio_fifo against a queue-based keyboard model.
module tb_ps2_kbd_mmio_fifo;

  localparam int          DEPTH = 16;
  localparam int          HW    = 2;
  localparam logic [31:0] BASE  = 32'hFF200100;

  logic        clk = 1'b0;
  logic        rst, scan_valid, rd_en, wr_en, irq, ovf;
  logic [7:0]  scan_code;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;

  always #5 clk = ~clk;

  ps2_kbd_mmio_fifo #(
    .FIFO_DEPTH (DEPTH),
    .HIST_WORDS (HW),
    .BASE_ADDR  (BASE)
  ) dut (
    .iCLK         (clk),
    .Reset        (rst),
    .iScanValid   (scan_valid),
    .iScanCode    (scan_code),
    .wReadEnable  (rd_en),
    .wWriteEnable (wr_en),
    .wByteEnable  (be),
    .wAddress     (addr),
    .wWriteData   (wdata),
    .wReadData    (rdata),
    .oInterrupt   (irq),
    .oOverflow    (ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [18:0]  m_q[$];
  logic [127:0] m_km;
  logic [7:0]   m_hist [4*HW];
  logic         m_ls, m_rs, m_caps, m_ovf, m_irq, m_prev_rd, m_ext_pend, m_brk_pend;
  int           m_skip;
  logic [31:0]  last_rd;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  string      digit_shift = ")!@#$%^&*(";

  function automatic logic [7:0] model_ascii(input logic [7:0] sc, input logic shift, input logic caps);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == sc) return ((shift ^ caps) ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == sc) return shift ? 8'(digit_shift[i]) : 8'h30 + 8'(i);
    case (sc)
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h0D: return 8'h09;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] off);
    logic [7:0] cnt8;
    cnt8 = 8'(m_q.size());
    if (off == 32'h0) return {16'b0, cnt8, 5'b0, m_irq, m_ovf, m_q.size() != 0};
    if (off == 32'h4) return (m_q.size() != 0) ? {1'b1, 12'b0, m_q[0]} : 32'h0;
    for (int k = 0; k < HW; k++)
      if (off == 32'h8 + 32'(4 * k))
        return {m_hist[4*k+3], m_hist[4*k+2], m_hist[4*k+1], m_hist[4*k]};
    for (int j = 0; j < 4; j++)
      if (off == 32'h28 + 32'(4 * j)) return m_km[32*j +: 32];
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_km = '0;
    for (int i = 0; i < 4*HW; i++) m_hist[i] = '0;
    m_ls = 0; m_rs = 0; m_caps = 0; m_ovf = 0; m_irq = 0; m_prev_rd = 0;
    m_ext_pend = 0; m_brk_pend = 0; m_skip = 0;
  endtask

  // Consume one byte: history, prefix flags, key map and modifiers; report any entry to queue
  task automatic model_byte(input logic [7:0] b, output logic push, output logic [18:0] ent);
    logic e;
    logic sh;
    push = 0;
    ent  = '0;
    for (int i = 4*HW-1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = b;
    if (m_skip > 0) m_skip--;
    else if (m_brk_pend) begin
      if (!m_ext_pend && b < 8'h80) m_km[b[6:0]] = 1'b0;
      if (b == 8'h12) m_ls = 0;
      if (b == 8'h59) m_rs = 0;
      m_brk_pend = 0;
      m_ext_pend = 0;
    end
    else if (b == 8'hF0) m_brk_pend = 1;
    else if (!m_ext_pend && b == 8'hE0) m_ext_pend = 1;
    else if (!m_ext_pend && b == 8'hE1) m_skip = 7;
    else begin
      e  = m_ext_pend;
      sh = m_ls | m_rs;
      if (!(b inside {8'h12, 8'h59, 8'h58, 8'h14, 8'h11})) begin
        push = 1;
        ent  = {m_caps, sh, e, b, e ? 8'h00 : model_ascii(b, sh, m_caps)};
      end
      if (!e && b < 8'h80) m_km[b[6:0]] = 1'b1;
      if (b == 8'h12) m_ls = 1;
      if (b == 8'h59) m_rs = 1;
      if (b == 8'h58) m_caps = ~m_caps;
      m_ext_pend = 0;
    end
  endtask

  // One clock cycle: drive, compare combinational outputs, advance the model, step the clock
  task automatic op(input logic v, input logic [7:0] b, input logic rd, input logic wr,
                    input logic [31:0] off, input logic [31:0] wd, input logic r);
    logic        is_data_rd, pop, push, ctrl_wr, set_ovf;
    logic [18:0] ent;
    int          had;
    scan_valid = v; scan_code = b; rd_en = rd; wr_en = wr;
    addr = BASE + off; wdata = wd; rst = r; be = 4'($urandom);
    #1;
    last_rd = rdata;
    check($sformatf("rdata@%0h", off), rdata, rd ? model_read(off) : 32'h0);
    check("irq", {31'b0, irq}, {31'b0, m_irq && (m_q.size() != 0)});
    check("ovf", {31'b0, ovf}, {31'b0, m_ovf});
    if (r) model_reset();
    else begin
      is_data_rd = rd && (off == 32'h4);
      pop        = is_data_rd && !m_prev_rd;
      m_prev_rd  = is_data_rd;
      push = 0; ent = '0; set_ovf = 0;
      if (v) model_byte(b, push, ent);
      ctrl_wr = wr && (off == 32'h0);
      if (ctrl_wr && wd[3]) m_q.delete();
      else begin
        had = m_q.size();
        if (pop && had > 0) void'(m_q.pop_front());
        if (push) begin
          if (had < DEPTH || (pop && had > 0)) m_q.push_back(ent);
          else set_ovf = 1;
        end
      end
      if (ctrl_wr) begin
        m_irq = wd[2];
        if (wd[1]) m_ovf = 0;
      end
      if (set_ovf) m_ovf = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] b);        op(1, b, 0, 0, 32'h0, 32'h0, 0); endtask
  task automatic rdreg(input logic [31:0] off);   op(0, 8'h0, 1, 0, off, 32'h0, 0); endtask
  task automatic wrreg(input logic [31:0] off, input logic [31:0] d); op(0, 8'h0, 0, 1, off, d, 0); endtask
  task automatic idle();                          op(0, 8'h0, 0, 0, 32'h0, 32'h0, 0); endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] mods [5];
    logic [7:0] misc [5];
    mods = '{8'h12, 8'h59, 8'h58, 8'h14, 8'h11};
    misc = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    r = $urandom_range(0, 99);
    if (r < 40) return letter_codes[$urandom_range(0, 25)];
    if (r < 50) return digit_codes[$urandom_range(0, 9)];
    if (r < 58) return mods[$urandom_range(0, 4)];
    if (r < 68) return 8'hF0;
    if (r < 73) return 8'hE0;
    if (r < 75) return 8'hE1;
    if (r < 82) return misc[$urandom_range(0, 4)];
    return 8'($urandom_range(0, 255));
  endfunction

  logic [31:0] offs [13] = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h8, 32'hC, 32'h10,
                             32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h6};
  logic [7:0]  pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    scan_valid = 0; scan_code = 0; rd_en = 0; wr_en = 0; be = 0;
    addr = 0; wdata = 0; rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    op(0, 8'h0, 0, 0, 32'h0, 32'h0, 1);
    op(0, 8'h0, 0, 0, 32'h0, 32'h0, 1);

    // Reset state
    rdreg(32'h0);  check("reset_ctrl", last_rd, 32'h0);
    rdreg(32'h4);  check("reset_data", last_rd, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);

    // Make/break of 'a'
    key(8'h1C);
    rdreg(32'h28); check("km0_b28_set", {31'b0, last_rd[28]}, 32'h1);
    key(8'hF0); key(8'h1C);
    rdreg(32'h28); check("km0_b28_clr", {31'b0, last_rd[28]}, 32'h0);
    rdreg(32'h8);  check("hist0", last_rd, 32'h001CF01C);
    rdreg(32'h4);  check("entry_a", last_rd, 32'h80001C61);

    // Shifted 'A' then plain 'a'; the shift make itself is not queued
    key(8'h12); key(8'h1C); key(8'hF0); key(8'h12); key(8'h1C);
    rdreg(32'h0);  check("count2", last_rd, 32'h00000201);
    rdreg(32'h4);  check("entry_A", last_rd, 32'h80021C41);
    idle();
    rdreg(32'h4);  check("entry_a2", last_rd, 32'h80001C61);
    key(8'hF0); key(8'h1C);

    // Extended key
    key(8'hE0); key(8'h75);
    rdreg(32'h4);  check("entry_ext", last_rd, 32'h80017500);
    rdreg(32'h34); check("km3_unchanged", last_rd, 32'h0);

    // Pause sequence swallowed, decoder back to idle
    foreach (pause_seq[i]) key(pause_seq[i]);
    key(8'h1C);
    rdreg(32'h0);  check("pause_count", last_rd, 32'h00000101);
    rdreg(32'h4);  check("pause_entry", last_rd, 32'h80001C61);
    key(8'hF0); key(8'h1C);

    // Overflow on the 17th make, then clear and flush
    for (int i = 0; i < DEPTH + 1; i++) key(8'h1C);
    rdreg(32'h0);  check("full_ctrl", last_rd, 32'h00001003);
    check("ovf_out", {31'b0, ovf}, 32'h1);
    wrreg(32'h0, 32'h2);
    rdreg(32'h0);  check("ovf_cleared", last_rd, 32'h00001001);
    key(8'hF0); key(8'h1C);
    wrreg(32'h0, 32'h8);
    rdreg(32'h0);  check("flushed", last_rd, 32'h0);

    // Interrupt and one pop per sustained DATA read
    wrreg(32'h0, 32'h4);
    key(8'h1C);
    check("irq_high", {31'b0, irq}, 32'h1);
    rdreg(32'h4);  check("held_rd0", last_rd, 32'h80001C61);
    rdreg(32'h4);
    rdreg(32'h4);
    rdreg(32'h0);  check("one_pop", last_rd, 32'h00000004);
    check("irq_low", {31'b0, irq}, 32'h0);
    key(8'hF0); key(8'h1C);

    // Reset in the middle of an E0 prefix
    key(8'hE0);
    op(0, 8'h0, 0, 0, 32'h0, 32'h0, 1);
    rdreg(32'h0);  check("midreset_ctrl", last_rd, 32'h0);
    key(8'hF0); key(8'h1C); key(8'h1C);
    rdreg(32'h0);  check("midreset_count", last_rd, 32'h00000101);
    rdreg(32'h4);  check("midreset_entry", last_rd, 32'h80001C61);
    key(8'hF0); key(8'h1C);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        v, rd, wr, r;
      logic [7:0]  b;
      logic [31:0] off, wd;
      v   = 1'($urandom_range(0, 1));
      b   = rand_byte();
      rd  = ($urandom_range(0, 9) < 3);
      wr  = ($urandom_range(0, 19) == 0);
      off = offs[$urandom_range(0, 12)];
      if (wr) off = ($urandom_range(0, 3) == 0) ? 32'h4 : 32'h0;
      wd  = 32'($urandom_range(0, 15));
      r   = ($urandom_range(0, 999) == 0);
      op(v, b, rd, wr, off, wd, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
